// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
//
// Load/store unit between the execute stage and a byte-lane data memory.
// It accepts one request at a time and handles lane steering, byte enables
// and sign/zero extension. A response comes back as a one-cycle pulse.
//
// Build option:
//   RISCV_LSU_MISALIGNED_EN  When defined, an access that crosses a word
//                            boundary is split into two word beats (ACC0 then
//                            ACC1). When undefined, such an access gets an
//                            error response and issues no memory cycle.
//
// Ports:
//   clk, rst_b        clock; synchronous active-high reset (rst_b=1 resets)
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1=store, 0=load
//   req_funct3        RV32I width code
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          invalid funct3, or misaligned without split support
//   mem_addr          word address (bits [1:0] always 0)
//   mem_data_in       write bytes, lanes 0..3
//   mem_data_out      read bytes, lanes 0..3 (combinational from mem_addr)
//   mem_write_en      write strobe
//   mem_byte_en       lane enables, bit i controls lane i
// -----------------------------------------------------------------------------
module riscv_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_in  [0:3],
    input  logic [7:0]        mem_data_out [0:3],
    output logic              mem_write_en,
    output logic [3:0]        mem_byte_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_reg;
    logic              write_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    // Captured load bytes, indexed by byte position within the access
    // (0 = lowest address), not by memory lane.
    logic [7:0]        cap_reg [0:3];

    // Access size in bytes from the width code (low two bits).
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic funct3_ok(input logic wr, input logic [2:0] f3);
        if (wr)
            funct3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            funct3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // ------------------------------------------------------------------
    // Decode from registered state
    // ------------------------------------------------------------------
    logic [1:0]        off;
    logic [2:0]        end_pos;     // off + size, up to 7
    logic [ADDR_W-1:0] word_addr;
    logic              in_acc0;
    logic              in_acc1;

    assign off       = addr_reg[1:0];
    assign end_pos   = {1'b0, off} + size_of(funct3_reg);
    assign word_addr = {addr_reg[ADDR_W-1:2], 2'b00};
    assign in_acc0   = (state_reg == ACC0);

`ifdef RISCV_LSU_MISALIGNED_EN
    logic spans_reg_based;
    assign spans_reg_based = (end_pos > 3'd4);
    assign in_acc1         = (state_reg == ACC1);
`else
    // Split beats are never issued in this build.
    assign in_acc1 = 1'b0;
    logic       req_spans;
    logic [2:0] req_end_pos;
    assign req_end_pos = {1'b0, req_addr[1:0]} + size_of(req_funct3);
    assign req_spans   = (req_end_pos > 3'd4);
`endif

    assign req_ready    = (state_reg == IDLE);
    assign mem_write_en = (in_acc0 || in_acc1) && write_reg;

    // Second beat addresses the next word; the addition wraps naturally.
    assign mem_addr = in_acc0 ? word_addr :
                      in_acc1 ? word_addr + ADDR_W'(4) :
                                '0;

    // Per-lane steering. The same left rotation by off serves both beats:
    // lane l carries access byte (l - off) mod 4.
    logic [1:0] lane_rot [0:3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);

            assign lane_rot[gi] = 2'(gi) - off;

            assign mem_byte_en[gi] =
                (in_acc0 && ({1'b0, off} <= LANE) && (LANE < end_pos)) ||
                (in_acc1 && ((LANE + 3'd4) < end_pos));

            assign mem_data_in[gi] = mem_write_en ?
                                     wdata_reg[{lane_rot[gi], 3'b000} +: 8] :
                                     8'h00;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response assembly (little-endian from captured bytes)
    // ------------------------------------------------------------------
    logic [31:0] load_data;

    always_comb begin
        load_data = 32'h0;
        case (funct3_reg)
            3'b000:  load_data = {{24{cap_reg[0][7]}}, cap_reg[0]};
            3'b001:  load_data = {{16{cap_reg[1][7]}}, cap_reg[1], cap_reg[0]};
            3'b010:  load_data = {cap_reg[3], cap_reg[2], cap_reg[1], cap_reg[0]};
            3'b100:  load_data = {24'h0, cap_reg[0]};
            3'b101:  load_data = {16'h0, cap_reg[1], cap_reg[0]};
            default: load_data = 32'h0;
        endcase
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_valid && err_reg;
    assign resp_rdata = (resp_valid && !err_reg && !write_reg) ? load_data : 32'h0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_reg  <= IDLE;
            write_reg  <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            err_reg    <= 1'b0;
            for (int i = 0; i < 4; i++) cap_reg[i] <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg  <= req_write;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        for (int i = 0; i < 4; i++) cap_reg[i] <= 8'h00;
                        if (!funct3_ok(req_write, req_funct3)) begin
                            err_reg   <= 1'b1;
                            state_reg <= RESP;
`ifndef RISCV_LSU_MISALIGNED_EN
                        end else if (req_spans) begin
                            err_reg   <= 1'b1;
                            state_reg <= RESP;
`endif
                        end else begin
                            err_reg   <= 1'b0;
                            state_reg <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    for (int l = 0; l < 4; l++)
                        if (mem_byte_en[l] && !write_reg)
                            cap_reg[lane_rot[l]] <= mem_data_out[l];
`ifdef RISCV_LSU_MISALIGNED_EN
                    state_reg <= spans_reg_based ? ACC1 : RESP;
`else
                    state_reg <= RESP;
`endif
                end
`ifdef RISCV_LSU_MISALIGNED_EN
                ACC1: begin
                    for (int l = 0; l < 4; l++)
                        if (mem_byte_en[l] && !write_reg)
                            cap_reg[lane_rot[l]] <= mem_data_out[l];
                    state_reg <= RESP;
                end
`endif
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// -----------------------------------------------------------------------------
// tb_riscv_lsu
//
// Self-checking bench for riscv_lsu. A byte-addressed reference memory
// (associative array keyed by full byte address) predicts load results,
// error flags, latency and the exact memory beats of each request. A
// separate byte-lane memory model serves the DUT's memory port.
// Honours RISCV_LSU_MISALIGNED_EN to select the expected split behaviour.
// -----------------------------------------------------------------------------
module tb_riscv_lsu;

`ifdef RISCV_LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic        mem_write_en;
    logic [3:0]  mem_byte_en;

    always #5 clk = ~clk;

    riscv_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_byte_en  (mem_byte_en)
    );

    // Memory port model: 1 KiB window, address bits [9:0].
    logic [7:0] env_mem [0:1023] = '{default: 8'h00};

    always_comb begin
        for (int l = 0; l < 4; l++)
            mem_data_out[l] = env_mem[{mem_addr[9:2], l[1:0]}];
    end

    always @(posedge clk) begin
        if (mem_write_en)
            for (int l = 0; l < 4; l++)
                if (mem_byte_en[l])
                    env_mem[{mem_addr[9:2], l[1:0]}] <= mem_data_in[l];
    end

    // Beat monitor.
    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] d;
    } beat_t;

    beat_t beats[$];

    always @(negedge clk) begin
        if (mem_byte_en != 4'b0000 || mem_write_en)
            beats.push_back('{a: mem_addr, be: mem_byte_en, we: mem_write_en,
                              d: {mem_data_in[3], mem_data_in[2],
                                  mem_data_in[1], mem_data_in[0]}});
    end

    // Reference memory.
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: predict, drive, observe, compare.
    task automatic run_txn(input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd_o, output logic err_o);
        logic        valid;
        int          size;
        int          off;
        logic        span;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] raw;
        beat_t       eb [0:1];
        int          nb;
        int          lat;
        logic [31:0] got_rd;
        logic        got_err;
        logic [31:0] mask;

        valid = w ? (f3 inside {3'd0, 3'd1, 3'd2})
                  : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        span  = (off + size) > 4;
        exp_err = !valid || (span && !MIS_EN);
        exp_lat = exp_err ? 1 : (span ? 3 : 2);
        exp_rd  = 32'h0;
        raw     = 32'h0;
        nb      = 0;
        eb[0]   = '0;
        eb[1]   = '0;

        if (!exp_err) begin
            for (int k = 0; k < size; k++) begin
                logic [31:0] ab;
                logic [31:0] wa;
                int          lane;
                ab   = a + 32'(k);
                wa   = ab & ~32'h3;
                lane = int'(ab[1:0]);
                if (nb == 0 || eb[nb-1].a != wa) begin
                    eb[nb] = '{a: wa, be: 4'b0000, we: w, d: 32'h0};
                    nb++;
                end
                eb[nb-1].be[lane] = 1'b1;
                if (w) begin
                    eb[nb-1].d[8*lane +: 8] = wd[8*k +: 8];
                    ref_mem[ab] = wd[8*k +: 8];
                end else begin
                    raw[8*k +: 8] = ref_rd(ab);
                end
            end
            if (!w) begin
                case (f3)
                    3'd0:    exp_rd = 32'($signed(raw[7:0]));
                    3'd1:    exp_rd = 32'($signed(raw[15:0]));
                    3'd4:    exp_rd = 32'(raw[7:0]);
                    3'd5:    exp_rd = 32'(raw[15:0]);
                    default: exp_rd = raw;
                endcase
            end
        end

        beats.delete();
        @(negedge clk);
        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        // Junk while busy must be ignored.
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat     = 0;
        got_rd  = 32'hx;
        got_err = 1'bx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat     = c;
                got_rd  = resp_rdata;
                got_err = resp_err;
                check_val("resp_mem_idle", {27'h0, mem_write_en, mem_byte_en}, 32'h0);
                break;
            end
        end
        req_valid = 1'b0;
        #1;

        n_txn++;
        $display("txn %0d: %s f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d beats=%0d",
                 n_txn, w ? "ST" : "LD", f3, a, wd, got_rd, got_err, lat, beats.size());

        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("resp_err", 32'(got_err), 32'(exp_err));
        check_val("resp_rdata", got_rd, exp_rd);
        check_val("beat_count", 32'(beats.size()), 32'(nb));
        if (beats.size() == nb) begin
            for (int i = 0; i < nb; i++) begin
                check_val("beat_addr", beats[i].a, eb[i].a);
                check_val("beat_be", 32'(beats[i].be), 32'(eb[i].be));
                check_val("beat_we", 32'(beats[i].we), 32'(eb[i].we));
                if (w) begin
                    for (int l = 0; l < 4; l++)
                        mask[8*l +: 8] = {8{eb[i].be[l]}};
                    check_val("beat_data", beats[i].d & mask, eb[i].d);
                end
            end
        end
        rd_o  = got_rd;
        err_o = got_err;
    endtask

    // Reset asserted while a store is mid-flight (ACC1 if split, else ACC0).
    task automatic reset_mid(input logic [31:0] a);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = a;
        req_wdata  = $urandom;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (MIS_EN) begin
            @(posedge clk);
            #1;
        end
        rst_b = 1'b1;
        @(negedge clk);
        check_val("rst_mid_busy_resp", 32'(resp_valid), 32'd0);
        check_val("rst_mid_busy_we", 32'(mem_write_en), 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check_val("rst_mid_resp", 32'(resp_valid), 32'd0);
        check_val("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check_val("rst_mid_resp2", 32'(resp_valid), 32'd0);
        n_txn++;
        $display("txn %0d: reset during store addr=%h", n_txn, a);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra;

        rst_b      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(resp_err), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_mem_we_be", {27'h0, mem_write_en, mem_byte_en}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_data_in", {mem_data_in[3], mem_data_in[2],
                                      mem_data_in[1], mem_data_in[0]}, 32'd0);

        // Aligned word store then load.
        run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, er);
        run_txn(1'b0, 3'd2, 32'h100, 32'h0, rd, er);
        check_val("lw_deadbeef", rd, 32'hDEADBEEF);

        // Byte/half extension.
        run_txn(1'b1, 3'd2, 32'h100, 32'h80FF7F01, rd, er);
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, rd, er);
        check_val("lb_103", rd, 32'hFFFFFF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, rd, er);
        check_val("lbu_103", rd, 32'h00000080);
        run_txn(1'b0, 3'd1, 32'h102, 32'h0, rd, er);
        check_val("lh_102", rd, 32'hFFFF80FF);
        run_txn(1'b0, 3'd5, 32'h102, 32'h0, rd, er);
        check_val("lhu_102", rd, 32'h000080FF);
        run_txn(1'b1, 3'd0, 32'h101, 32'h12345699, rd, er);
        run_txn(1'b0, 3'd2, 32'h100, 32'h0, rd, er);
        check_val("lw_after_sb", rd, 32'h80FF9901);

        // Misaligned accesses (split or error depending on build).
        run_txn(1'b0, 3'd2, 32'h0FE, 32'h0, rd, er);
        run_txn(1'b1, 3'd2, 32'hFFFFFFFF, 32'hA1B2C3D4, rd, er);
        run_txn(1'b0, 3'd1, 32'h103, 32'h0, rd, er);
        check_val("lh_103_err", 32'(er), 32'(!MIS_EN));

        // Invalid width codes.
        run_txn(1'b0, 3'd3, 32'h100, 32'h0, rd, er);
        check_val("inv_ld_err", 32'(er), 32'd1);
        check_val("inv_ld_rdata", rd, 32'd0);
        run_txn(1'b1, 3'd4, 32'h104, 32'h55AA55AA, rd, er);
        check_val("inv_st_err", 32'(er), 32'd1);

        // Reset mid-operation, then rewrite the touched word(s) to resync.
        ra = MIS_EN ? 32'h1FE : 32'h1FC;
        reset_mid(ra);
        run_txn(1'b1, 3'd2, ra, 32'h0BADF00D, rd, er);
        if (!MIS_EN) begin
            run_txn(1'b0, 3'd2, ra, 32'h0, rd, er);
            check_val("lw_after_rst", rd, 32'h0BADF00D);
        end else begin
            run_txn(1'b1, 3'd2, 32'h1FC, 32'h11223344, rd, er);
            run_txn(1'b1, 3'd2, 32'h200, 32'h55667788, rd, er);
            run_txn(1'b0, 3'd2, ra, 32'h0, rd, er);
            check_val("lw_after_rst", rd, 32'h77881122);
        end

        // Randomized traffic in a non-aliasing window.
        for (int t = 0; t < 300; t++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'h100 + 32'($urandom_range(0, 511)), $urandom, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the core's execute stage and the byte-lane data memory port. Accepts one load or store request at a time and performs byte-lane steering, byte enables, sign/zero extension and, optionally, splitting of misaligned accesses into two word beats. Returns a single-cycle response carrying load data or an error flag.

## Interface

Parameters:
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock, rising edge; the only clock.
- rst_b  in  1  reset, synchronous, active-high (`rst_b`=1 resets on the next rising edge).
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; the request is accepted in a cycle where `req_valid` and `req_ready` are both 1.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse; there is no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and for errors.
- resp_err  out  1  invalid funct3, or misaligned access when splitting is not compiled in.
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0.
- mem_data_in  out  4x8  write bytes, lanes [0:3].
- mem_data_out  in  4x8  read bytes, lanes [0:3], combinational from `mem_addr`.
- mem_write_en  out  1  write strobe; memory writes enabled lanes on the rising edge.
- mem_byte_en  out  4  lane enables, bit i controls lane i.

## Operation

- FSM states: IDLE, ACC0, ACC1, RESP.
- `req_ready` = (state==IDLE).
- **IDLE:** on accept, register `write`, `funct3`, `addr` and `wdata`.
  - Invalid funct3 goes directly to RESP with err=1.
  - Otherwise the FSM goes to ACC0.
- **Size and split:** size = 1/2/4 bytes; off = addr[1:0]. The access spans two words when off+size>4.
- **ACC0:**
  - `mem_addr` = addr & ~3.
  - Active lanes are off .. min(off+size,4)-1.
  - Stores: data bytes are rotated left by off into the lanes; `mem_write_en`=1 for this cycle.
  - Loads: the active lanes are captured at the end of the cycle.
  - Next state is ACC1 if the access spans two words, else RESP.
- **ACC1:**
  - `mem_addr` = (addr & ~3) + 4, computed modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0.
  - Active lanes are 0 .. off+size-5, carrying the remaining upper bytes.
  - Stores write with `mem_write_en`=1; loads capture.
  - Next state is RESP.
- **RESP:**
  - `resp_valid`=1.
  - `resp_rdata` is assembled little-endian from the captured bytes. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Next state is IDLE.
- **Idle outputs:** outside ACC0/ACC1, `mem_write_en`=0, `mem_byte_en`=0, `mem_addr`=0 and `mem_data_in`=0.
- **Reset:** reset in any state returns the FSM to IDLE on that edge. An in-flight request is dropped with no response. A beat already written is not rolled back.

## Timing

- **Reset values:**
  - `req_ready`=1.
  - `resp_valid`, `resp_err`, `mem_write_en` and `mem_byte_en` = 0.
  - `resp_rdata`, `mem_addr` and `mem_data_in` = 0.
- **Latency (accept cycle = 0):**
  - Aligned or single-word access: `resp_valid` in cycle 2.
  - Split access: `resp_valid` in cycle 3.
  - Error: `resp_valid` in cycle 1.
- **Throughput:** a new request can be accepted in the cycle after RESP. The minimum interval is 3 cycles (aligned) or 4 cycles (split).
- **Inputs:** request inputs are ignored while `req_ready`=0; `req_*` may change freely after acceptance.
- **Registered outputs:** `resp_rdata` and `resp_err` are registered and valid only while `resp_valid`=1.
- **Decoded outputs:** memory-port outputs are decoded from registered state only; there is no combinational path from `req_*` to `mem_*`.

## Configuration

- **`RISCV_LSU_MISALIGNED_EN` defined:** two-word accesses use ACC1 as described above.
- **`RISCV_LSU_MISALIGNED_EN` undefined:**
  - Any access with off+size>4 goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0.
  - No memory cycle is issued and `mem_write_en` stays 0.
  - ACC1 is not synthesized.
- In both builds, invalid funct3 sets `resp_err`.

## Test plan

- **Reset:** hold `rst_b`=1 for 2 cycles, then release → `req_ready`=1 and all other outputs 0.
- **Aligned SW then LW:** SW addr 0x100, wdata 0xDEADBEEF → `mem_write_en`=1 for one cycle with `mem_byte_en`=1111, lanes EF,BE,AD,DE. Then LW 0x100 → `resp_rdata`=0xDEADBEEF in cycle 2.
- **Byte and half extension:** with memory word 0x100 = 0x80FF7F01:
  - LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF80FF; LHU 0x102 → 0x000080FF.
  - SB 0x101, wdata 0x12345699 → `mem_byte_en`=0010, lane1=0x99.
- **Misaligned with `RISCV_LSU_MISALIGNED_EN`:** LW 0x0FE → beat 0x0FC with lanes 2–3, beat 0x100 with lanes 0–1, `resp_valid` in cycle 3. SW 0xFFFFFFFF → second beat `mem_addr`=0x00000000, `mem_byte_en`=0111.
- **Misaligned without the macro:** LH 0x103 → `resp_err`=1 in cycle 1, no `mem_write_en`/`mem_byte_en` activity.
- **Invalid and reset mid-op:**
  - funct3=011 load → `resp_err`=1, `resp_rdata`=0.
  - Assert reset during ACC1 of a split SW → no `resp_valid`, state IDLE, `req_ready`=1 on the next cycle.
